// File: rtl/multi_pulse_generator_pkg.sv
// Shared types for the multi-channel pulse generator: edge-select encodings,
// per-channel state encoding and the edge qualification helper.
package multi_pulse_generator_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_sel_e;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_ACTIVE = 1'b1
  } chan_state_e;

  // True when the prev->cur transition matches the selected start condition.
  function automatic logic edge_qualified(input edge_sel_e sel,
                                          input logic      prev,
                                          input logic      cur);
    logic q;
    q = 1'b0;
    case (sel)
      EDGE_RISE: q = ~prev &  cur;
      EDGE_FALL: q =  prev & ~cur;
      EDGE_BOTH: q =  prev ^  cur;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/multi_pulse_generator_if.sv
// Control/status bundle of the pulse generator; master drives the controls,
// slave (the generator) drives the pulse/status outputs.
interface multi_pulse_generator_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 16
);
  logic                enable;
  logic [CHANNELS-1:0] trigger;
  logic [1:0]          edge_sel;
  logic                retrigger;
  logic [CNT_W-1:0]    width;
  logic                clear_missed;
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] done;
  logic [CHANNELS-1:0] missed;
  logic                busy;

  modport master (
    output enable, trigger, edge_sel, retrigger, width, clear_missed,
    input  pulse, done, missed, busy
  );

  modport slave (
    input  enable, trigger, edge_sel, retrigger, width, clear_missed,
    output pulse, done, missed, busy
  );
endinterface

// File: rtl/multi_pulse_generator_pulse_channel.sv
// One pulse channel: trigger edge detector, pulse-width counter and the
// IDLE/ACTIVE state machine with retrigger/missed handling.
module pulse_channel
  import multi_pulse_generator_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             trigger,
  input  edge_sel_e        edge_sel,
  input  logic             retrigger,
  input  logic [CNT_W-1:0] width,
  input  logic             clear_missed,
  output logic             pulse,
  output logic             done,
  output logic             missed
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;
  logic             missed_q, missed_d;
  logic             start;
  logic [CNT_W-1:0] load_len;

  // enable gates only the use of an edge; prev always follows trigger.
  assign start    = enable & edge_qualified(edge_sel, prev_q, trigger);
  assign load_len = (width == '0) ? CNT_W'(1) : width;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    missed_d = missed_q & ~clear_missed;
    case (state_q)
      CH_IDLE: begin
        if (start) begin
          state_d = CH_ACTIVE;
          cnt_d   = load_len;
        end
      end
      CH_ACTIVE: begin
        // A restart on the final count cycle wins over expiry, so no done.
        if (start && retrigger) begin
          cnt_d = load_len;
        end else begin
          if (start) begin
            missed_d = 1'b1;
          end
          if (cnt_q <= CNT_W'(1)) begin
            state_d = CH_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = CH_IDLE;
        cnt_d   = '0;
      end
    endcase
    pulse_d = (state_d == CH_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CH_IDLE;
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= trigger;
      pulse_q  <= pulse_d;
      done_q   <= done_d;
      missed_q <= missed_d;
    end
  end

  assign pulse  = pulse_q;
  assign done   = done_q;
  assign missed = missed_q;

endmodule

// File: rtl/multi_pulse_generator.sv
// Multi-channel pulse generator top: replicates pulse_channel per trigger bit
// and derives the aggregate busy flag.
module multi_pulse_generator
  import multi_pulse_generator_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multi_pulse_generator_if.slave  bus
);

  logic [CHANNELS-1:0] pulse_w;
  logic [CHANNELS-1:0] done_w;
  logic [CHANNELS-1:0] missed_w;
  edge_sel_e           edge_sel;

  assign edge_sel = edge_sel_e'(bus.edge_sel);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulse_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (bus.enable),
      .trigger      (bus.trigger[i]),
      .edge_sel     (edge_sel),
      .retrigger    (bus.retrigger),
      .width        (bus.width),
      .clear_missed (bus.clear_missed),
      .pulse        (pulse_w[i]),
      .done         (done_w[i]),
      .missed       (missed_w[i])
    );
  end

  assign bus.pulse  = pulse_w;
  assign bus.done   = done_w;
  assign bus.missed = missed_w;
  assign bus.busy   = |pulse_w;

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Directed bench for multi_pulse_generator: stimulus queues hand-computed
// per-cycle expectations, an independent negedge monitor checks them.
module tb_multi_pulse_generator;

  localparam int unsigned CH = 4;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multi_pulse_generator_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  multi_pulse_generator #(.CHANNELS(CH), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int unsigned at;
    logic [3:0]  p;
    logic [3:0]  d;
    logic [3:0]  m;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  always @(posedge clk) cyc++;

  // Monitor: every sampled cycle with a queued expectation is compared.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      compared++;
      if (e.at != cyc) begin
        mismatched++;
        $display("FAIL %s: expectation for cycle %0d seen at cycle %0d", e.nm, e.at, cyc);
      end else if (bus.pulse !== e.p || bus.done !== e.d || bus.missed !== e.m ||
                   bus.busy !== (|e.p)) begin
        mismatched++;
        $display("FAIL %s @cyc %0d: pulse/done/missed/busy = %b/%b/%b/%b, required %b/%b/%b/%b",
                 e.nm, cyc, bus.pulse, bus.done, bus.missed, bus.busy, e.p, e.d, e.m, |e.p);
      end
    end
  end

  task automatic expect_at(input int unsigned at, input logic [3:0] p,
                           input logic [3:0] d, input logic [3:0] m, input string nm);
    exp_t e;
    e.at = at; e.p = p; e.d = d; e.m = m; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb.size() > 0; i++) tick();
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d expectations pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    rst_n            = 1'b0;
    bus.enable       = 1'b1;
    bus.trigger      = '0;
    bus.edge_sel     = 2'b00;
    bus.retrigger    = 1'b1;
    bus.width        = 16'd5;
    bus.clear_missed = 1'b0;

    // Reset state
    tick();
    expect_at(cyc, 4'b0000, 4'b0000, 4'b0000, "reset_state");
    expect_at(cyc + 1, 4'b0000, 4'b0000, 4'b0000, "reset_state");
    tick(); tick();
    rst_n = 1'b1;
    expect_at(cyc + 1, 4'b0000, 4'b0000, 4'b0000, "post_reset_idle");
    drain();

    // Basic rising-edge pulse, width 5 on ch0
    t = cyc + 1;
    bus.trigger[0] = 1'b1;
    for (int k = 0; k < 5; k++) expect_at(t + k, 4'b0001, 4'b0000, 4'b0000, "basic_pulse");
    expect_at(t + 5, 4'b0000, 4'b0001, 4'b0000, "basic_done");
    expect_at(t + 6, 4'b0000, 4'b0000, 4'b0000, "basic_end");
    drain();

    // Falling edge does not start a pulse in rise mode
    t = cyc + 1;
    bus.trigger[0] = 1'b0;
    for (int k = 0; k < 3; k++) expect_at(t + k, 4'b0000, 4'b0000, 4'b0000, "rise_ignores_fall");
    drain();

    // Retrigger on: width 4, ch1 rises at T and T+2
    bus.width = 16'd4;
    bus.retrigger = 1'b1;
    t = cyc + 1;
    bus.trigger[1] = 1'b1;
    for (int k = 0; k < 6; k++) expect_at(t + k, 4'b0010, 4'b0000, 4'b0000, "retrig_on_pulse");
    expect_at(t + 6, 4'b0000, 4'b0010, 4'b0000, "retrig_on_done");
    expect_at(t + 7, 4'b0000, 4'b0000, 4'b0000, "retrig_on_end");
    tick(); bus.trigger[1] = 1'b0;
    tick(); bus.trigger[1] = 1'b1;
    drain();
    bus.trigger[1] = 1'b0;
    tick();

    // Retrigger off; clear_missed coincides with the miss, so the miss wins
    bus.retrigger = 1'b0;
    t = cyc + 1;
    bus.trigger[1] = 1'b1;
    expect_at(t,     4'b0010, 4'b0000, 4'b0000, "retrig_off_pulse");
    expect_at(t + 1, 4'b0010, 4'b0000, 4'b0000, "retrig_off_pulse");
    expect_at(t + 2, 4'b0010, 4'b0000, 4'b0010, "miss_beats_clear");
    expect_at(t + 3, 4'b0010, 4'b0000, 4'b0010, "retrig_off_count");
    expect_at(t + 4, 4'b0000, 4'b0010, 4'b0010, "retrig_off_done");
    expect_at(t + 5, 4'b0000, 4'b0000, 4'b0010, "missed_sticky");
    tick(); bus.trigger[1] = 1'b0;
    tick(); bus.trigger[1] = 1'b1; bus.clear_missed = 1'b1;
    tick(); bus.clear_missed = 1'b0;
    drain();
    bus.trigger[1] = 1'b0;
    expect_at(cyc, 4'b0000, 4'b0000, 4'b0010, "missed_held");
    bus.clear_missed = 1'b1;
    expect_at(cyc + 1, 4'b0000, 4'b0000, 4'b0000, "missed_cleared");
    tick();
    bus.clear_missed = 1'b0;
    expect_at(cyc + 1, 4'b0000, 4'b0000, 4'b0000, "missed_stays_clear");
    drain();

    // Restart on the last active cycle extends the pulse, no intermediate done
    bus.retrigger = 1'b1;
    bus.width = 16'd2;
    t = cyc + 1;
    bus.trigger[0] = 1'b1;
    for (int k = 0; k < 4; k++) expect_at(t + k, 4'b0001, 4'b0000, 4'b0000, "end_cycle_restart");
    expect_at(t + 4, 4'b0000, 4'b0001, 4'b0000, "end_cycle_done");
    expect_at(t + 5, 4'b0000, 4'b0000, 4'b0000, "end_cycle_end");
    tick(); bus.trigger[0] = 1'b0;
    tick(); bus.trigger[0] = 1'b1;
    drain();
    bus.trigger[0] = 1'b0;
    tick();

    // Both edges, width 0 behaves as 1, ch2 toggles every 3 cycles
    bus.edge_sel = 2'b10;
    bus.width = 16'd0;
    for (int i = 0; i < 3; i++) begin
      t = cyc + 1;
      bus.trigger[2] = ~bus.trigger[2];
      expect_at(t,     4'b0100, 4'b0000, 4'b0000, "both_w0_pulse");
      expect_at(t + 1, 4'b0000, 4'b0100, 4'b0000, "both_w0_done");
      expect_at(t + 2, 4'b0000, 4'b0000, 4'b0000, "both_w0_gap");
      tick(); tick(); tick();
    end
    drain();

    // Edge select "none": dropping ch2 starts nothing
    bus.edge_sel = 2'b11;
    bus.trigger = '0;
    expect_at(cyc + 1, 4'b0000, 4'b0000, 4'b0000, "edge_none");
    expect_at(cyc + 2, 4'b0000, 4'b0000, 4'b0000, "edge_none");
    drain();

    // All channels start together
    bus.edge_sel = 2'b00;
    bus.width = 16'd3;
    t = cyc + 1;
    bus.trigger = 4'b1111;
    for (int k = 0; k < 3; k++) expect_at(t + k, 4'b1111, 4'b0000, 4'b0000, "multi_pulse");
    expect_at(t + 3, 4'b0000, 4'b1111, 4'b0000, "multi_done");
    expect_at(t + 4, 4'b0000, 4'b0000, 4'b0000, "multi_end");
    drain();
    bus.trigger = '0;
    tick();

    // enable=0 blocks the start; prev keeps tracking so no late start
    bus.enable = 1'b0;
    bus.width = 16'd5;
    t = cyc + 1;
    bus.trigger[3] = 1'b1;
    for (int k = 0; k < 4; k++) expect_at(t + k, 4'b0000, 4'b0000, 4'b0000, "enable_blocks");
    drain();
    bus.enable = 1'b1;
    expect_at(cyc + 1, 4'b0000, 4'b0000, 4'b0000, "no_late_start");
    expect_at(cyc + 2, 4'b0000, 4'b0000, 4'b0000, "no_late_start");
    drain();
    bus.trigger[3] = 1'b0;
    tick();

    // Reset on the 2nd pulse cycle, then trigger held high across release
    bus.width = 16'd8;
    t = cyc + 1;
    bus.trigger[0] = 1'b1;
    expect_at(t,     4'b0001, 4'b0000, 4'b0000, "rst_pulse_start");
    expect_at(t + 1, 4'b0000, 4'b0000, 4'b0000, "rst_async_drop");
    expect_at(t + 2, 4'b0000, 4'b0000, 4'b0000, "rst_held");
    expect_at(t + 3, 4'b0000, 4'b0000, 4'b0000, "rst_held");
    for (int k = 0; k < 8; k++) expect_at(t + 4 + k, 4'b0001, 4'b0000, 4'b0000, "release_rise");
    expect_at(t + 12, 4'b0000, 4'b0001, 4'b0000, "release_done");
    expect_at(t + 13, 4'b0000, 4'b0000, 4'b0000, "release_end");
    tick();
    tick(); rst_n = 1'b0;
    tick();
    tick(); rst_n = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multi_pulse_generator.md
MULTI_PULSE_GENERATOR -- requirements
Module: multi_pulse_generator

Interface
REQ-001 Parameters SHALL be: CHANNELS, default 4, number of independent pulse channels (1..32).
REQ-002 Parameters SHALL include: CNT_W, default 16, bit width of the pulse-width counter.
REQ-003 Port clk  input  1  is the single clock; all logic SHALL be rising-edge clocked.
REQ-004 Port rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Port enable  input  1  SHALL gate new-pulse starts; 1 = edges accepted.
REQ-006 Port trigger  input  CHANNELS  SHALL carry one synchronous trigger level per channel.
REQ-007 Port edge_sel  input  2  SHALL select the start condition: 00 rising, 01 falling, 10 both, 11 none.
REQ-008 Port retrigger  input  1  SHALL select the active-edge policy: 1 = restart the count, 0 = ignore the edge and flag it.
REQ-009 Port width  input  CNT_W  SHALL give the pulse length in clk cycles; it is sampled at each start or restart.
REQ-010 Port clear_missed  input  1  SHALL synchronously clear all missed flags.
REQ-011 Port pulse  output  CHANNELS  SHALL carry the registered pulse outputs.
REQ-012 Port done  output  CHANNELS  SHALL give a one-cycle strobe per channel when its pulse ends.
REQ-013 Port missed  output  CHANNELS  SHALL give sticky per-channel flags for ignored edges.
REQ-014 Port busy  output  1  SHALL be the OR of all pulse bits.

Function
REQ-015 Each channel SHALL register its previous trigger value (prev); an edge is detected on any cycle where trigger differs from prev, and is then qualified by edge_sel.
REQ-016 Each channel SHALL have exactly two states: IDLE and ACTIVE.
REQ-017 IDLE -> ACTIVE: a qualified edge with enable=1 SHALL load the counter with max(width,1) and set pulse high from the next clock edge.
REQ-018 Pulse length: pulse SHALL stay high for exactly max(width,1) cycles; width=0 behaves as 1.
REQ-019 Latency: an edge sampled at clock edge T SHALL give pulse=1 for cycles T+1 .. T+N, where N = max(width,1).
REQ-020 ACTIVE -> IDLE: after the count expires, pulse SHALL go 0 and done SHALL be 1 for that single first low cycle.
REQ-021 Retrigger, retrigger=1: a qualified edge while ACTIVE SHALL reload the counter with max(width,1); pulse stays high without a gap and no done is issued for the truncated pulse.
REQ-022 Retrigger, retrigger=0: a qualified edge while ACTIVE SHALL be ignored and SHALL set missed[i]; the count is unaffected.
REQ-023 End-cycle edge: an edge on the last ACTIVE cycle SHALL follow REQ-021/REQ-022; it does not start a fresh pulse after done.
REQ-024 Enable: enable=0 SHALL block new starts and restarts and SHALL NOT set missed; in-flight pulses run to completion; prev keeps tracking trigger.
REQ-025 Width changes: a change on width mid-pulse SHALL NOT affect the running count.
REQ-026 clear_missed: clear_missed=1 SHALL clear missed; if a new miss occurs in the same cycle, missed SHALL remain set.
REQ-027 Channel independence: channels SHALL be fully independent; simultaneous edges on several channels all start.

Reset
REQ-028 While rst_n=0, the following SHALL be 0: pulse, done, missed, busy, counters and prev; all channels SHALL be in IDLE.
REQ-029 A trigger held high at reset release SHALL count as a rising edge on the first clocked cycle.
REQ-030 Reset asserted mid-pulse SHALL drop pulse immediately (asynchronously) with no done.

Structure
REQ-031 A shared package SHALL hold the edge_sel encodings (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_NONE) and the channel state encoding.
REQ-032 Sub-module pulse_channel (one trigger, counter, FSM) SHALL be instantiated CHANNELS times via generate; the top level holds only busy, fan-out and parameter passing.

Verification
REQ-033 Basic pulse: edge_sel=00, width=5, ch0 rises at T -> pulse[0]=1 for T+1..T+5, done[0]=1 at T+6.
REQ-034 Retrigger on: width=4, retrigger=1, ch1 rises at T and again at T+2 -> pulse[1] high T+1..T+6, single done at T+7, missed[1]=0.
REQ-035 Retrigger off: same stimulus with retrigger=0 -> pulse high T+1..T+4, missed[1]=1 until clear_missed pulses, then 0.
REQ-036 Both-edge mode and width=0: edge_sel=10, width=0, toggle ch2 every 3 cycles -> a one-cycle pulse after each toggle, done the following cycle.
REQ-037 Enable and reset: enable=0 during a rise gives no pulse; rst_n dropped at the 2nd cycle of a width=8 pulse gives pulse=0 at once and no done.
